// File: rtl/reg_write_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// REG_ARB_PC_PRIORITY_EN (optional define) gives requester 0 absolute priority in ARB.
package reg_arb_pkg;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Register-file indices; REG_PC also names the fetch requester slot.
    localparam int REG_PC       = 0;
    localparam int REG_CACHEPTR = 1;
    localparam int REG_STACKPTR = 2;
    localparam int REG_HEADPTR  = 3;
    localparam int REG_REGISTER = 4;

    localparam int DEF_NUM_REQ  = 4;
    localparam int DEF_ADDR_W   = 3;
    localparam int DEF_DATA_W   = 8;
    localparam int DEF_LOCK_MAX = 4;

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Request/grant and register-file write bundle between datapath units and the arbiter.
interface reg_write_arbiter_if
    import reg_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W
);
    logic [NUM_REQ-1:0]             req_i;
    logic [NUM_REQ-1:0]             lock_i;
    logic [NUM_REQ-1:0][ADDR_W-1:0] addr_i;
    logic [NUM_REQ-1:0][DATA_W-1:0] data_i;
    logic [NUM_REQ-1:0]             gnt_o;
    logic                           wen_o;
    logic [ADDR_W-1:0]              wa_o;
    logic [DATA_W-1:0]              write_data_o;
    logic                           busy_o;

    modport master (
        output req_i, lock_i, addr_i, data_i,
        input  gnt_o, wen_o, wa_o, write_data_o, busy_o
    );

    modport slave (
        input  req_i, lock_i, addr_i, data_i,
        output gnt_o, wen_o, wa_o, write_data_o, busy_o
    );
endinterface

// File: rtl/reg_write_arbiter_rr_picker.sv
// Combinational rotating-base priority picker: first set req bit at or after base, wrapping.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   base,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);
    always_comb begin
        int k;
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        k     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = (int'(base) + i) % NUM_REQ;
            if (!valid && req[k]) begin
                valid  = 1'b1;
                idx    = IDX_W'(k);
                gnt[k] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter with per-requester lock for the register-file write port.
// Optional define REG_ARB_PC_PRIORITY_EN: requester 0 (fetch/PC) always wins in ARB.
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int LOCK_MAX = DEF_LOCK_MAX
) (
    input logic               clk,
    input logic               reset,
    reg_write_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        if (int'(i) == NUM_REQ - 1) return '0;
        return i + 1'b1;
    endfunction

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic               wen_q, wen_d;
    logic [ADDR_W-1:0]  wa_q, wa_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;

    logic [NUM_REQ-1:0] pick_gnt, arb_gnt, gnt;
    logic [IDX_W-1:0]   pick_idx, arb_idx, win_idx;
    logic               pick_valid, arb_valid;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req   (bus.req_i),
        .base  (rr_ptr_q),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        lock_cnt_d = lock_cnt_q;
        gnt        = '0;
        win_idx    = '0;
        arb_gnt    = pick_gnt;
        arb_idx    = pick_idx;
        arb_valid  = pick_valid;
`ifdef REG_ARB_PC_PRIORITY_EN
        if (bus.req_i[REG_PC]) begin
            arb_gnt         = '0;
            arb_gnt[REG_PC] = 1'b1;
            arb_idx         = IDX_W'(REG_PC);
            arb_valid       = 1'b1;
        end
`endif
        unique case (state_q)
            ARB: begin
                if (arb_valid) begin
                    gnt     = arb_gnt;
                    win_idx = arb_idx;
                    if (bus.lock_i[arb_idx]) begin
                        owner_d    = arb_idx;
                        lock_cnt_d = CNT_W'(1);
                        state_d    = LOCKED;
                    end else begin
`ifdef REG_ARB_PC_PRIORITY_EN
                        if (arb_idx != IDX_W'(REG_PC)) rr_ptr_d = next_idx(arb_idx);
`else
                        rr_ptr_d = next_idx(arb_idx);
`endif
                    end
                end
            end
            LOCKED: begin
                gnt[owner_q] = bus.req_i[owner_q];
                win_idx      = owner_q;
                // The cap is counted whether or not the owner requests, so a stalled owner can't starve others.
                if (!bus.lock_i[owner_q] || lock_cnt_q == CNT_W'(LOCK_MAX)) begin
                    state_d    = ARB;
                    rr_ptr_d   = next_idx(owner_q);
                    lock_cnt_d = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end
            end
            default: state_d = ARB;
        endcase
        if (reset) gnt = '0;

        wen_d   = |gnt;
        wa_d    = wa_q;
        wdata_d = wdata_q;
        if (|gnt) begin
            wa_d    = bus.addr_i[win_idx];
            wdata_d = bus.data_i[win_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ARB;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            lock_cnt_q <= '0;
            wen_q      <= 1'b0;
            wa_q       <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            lock_cnt_q <= lock_cnt_d;
            wen_q      <= wen_d;
            wa_q       <= wa_d;
            wdata_q    <= wdata_d;
        end
    end

    assign bus.gnt_o        = gnt;
    assign bus.busy_o       = (state_q == LOCKED) && !reset;
    assign bus.wen_o        = wen_q;
    assign bus.wa_o         = wa_q;
    assign bus.write_data_o = wdata_q;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: directed scenarios plus randomized traffic vs a reference model.
module tb_reg_write_arbiter;
    localparam int NUM_REQ  = 4;
    localparam int ADDR_W   = 3;
    localparam int DATA_W   = 8;
    localparam int LOCK_MAX = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    reg_write_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    reg_write_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOCK_MAX(LOCK_MAX)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: who holds the port, where the rotation starts, what gets written next cycle.
    bit                m_locked;
    int                m_rr, m_owner, m_cnt;
    logic              m_wen;
    logic [ADDR_W-1:0] m_wa;
    logic [DATA_W-1:0] m_wd;
    int                e_win;
    logic [NUM_REQ-1:0] e_gnt;
    logic              e_busy;

    task automatic model_eval();
        e_win = -1;
        if (!reset) begin
            if (!m_locked) begin
                for (int off = 0; off < NUM_REQ; off++)
                    if (e_win < 0 && bus.req_i[(m_rr + off) % NUM_REQ]) e_win = (m_rr + off) % NUM_REQ;
`ifdef REG_ARB_PC_PRIORITY_EN
                if (bus.req_i[0]) e_win = 0;
`endif
            end else if (bus.req_i[m_owner]) begin
                e_win = m_owner;
            end
        end
        e_gnt  = (e_win < 0) ? '0 : NUM_REQ'(1 << e_win);
        e_busy = m_locked && !reset;
    endtask

    task automatic model_commit();
        if (reset) begin
            m_locked = 0; m_rr = 0; m_owner = 0; m_cnt = 0;
            m_wen = 1'b0; m_wa = '0; m_wd = '0;
            return;
        end
        m_wen = (e_win >= 0);
        if (e_win >= 0) begin
            m_wa = bus.addr_i[e_win];
            m_wd = bus.data_i[e_win];
        end
        if (!m_locked) begin
            if (e_win >= 0) begin
                if (bus.lock_i[e_win]) begin
                    m_locked = 1; m_owner = e_win; m_cnt = 1;
                end else begin
`ifdef REG_ARB_PC_PRIORITY_EN
                    if (e_win != 0) m_rr = (e_win + 1) % NUM_REQ;
`else
                    m_rr = (e_win + 1) % NUM_REQ;
`endif
                end
            end
        end else if (!bus.lock_i[m_owner] || m_cnt == LOCK_MAX) begin
            m_locked = 0; m_rr = (m_owner + 1) % NUM_REQ; m_cnt = 0;
        end else begin
            m_cnt++;
        end
    endtask

    task automatic settle();
        #1;
        model_eval();
    endtask

    task automatic tick();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic drive_idle();
        bus.req_i  = '0;
        bus.lock_i = '0;
        bus.addr_i = '0;
        bus.data_i = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive_idle();
        settle(); tick();
        settle(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.req_i  = '1;
        bus.lock_i = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            bus.addr_i[k] = ADDR_W'($urandom);
            bus.data_i[k] = DATA_W'($urandom);
        end
        bus.addr_i[0] = 3'd5;
        bus.data_i[0] = 8'h5A;
        settle();
        n_vec++;
        if ({bus.gnt_o, bus.busy_o} !== 5'b0) begin
            n_err++; $display("FAIL reset_gnt got gnt=%b busy=%b want 0000/0", bus.gnt_o, bus.busy_o);
        end
        tick(); settle();
        n_vec++;
        if ({bus.wen_o, bus.wa_o, bus.write_data_o} !== 12'h000) begin
            n_err++; $display("FAIL reset_wr got wen=%b wa=%0d wd=%h want 0/0/00", bus.wen_o, bus.wa_o, bus.write_data_o);
        end
        reset = 1'b0;
        settle();
        n_vec++;
        if (bus.gnt_o !== 4'b0001) begin
            n_err++; $display("FAIL release_gnt got %b want 0001", bus.gnt_o);
        end
        tick();
        bus.req_i = '0;
        settle();
        n_vec++;
        if ({bus.wen_o, bus.wa_o, bus.write_data_o} !== {1'b1, 3'd5, 8'h5A}) begin
            n_err++; $display("FAIL release_wr got wen=%b wa=%0d wd=%h want 1/5/5a", bus.wen_o, bus.wa_o, bus.write_data_o);
        end
    endtask

    // Also covers PC priority: with the define every cycle goes to requester 0.
    task automatic test_round_robin();
        logic [NUM_REQ-1:0] spec_g;
        do_reset();
        bus.req_i  = '1;
        bus.lock_i = '0;
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                bus.addr_i[k] = ADDR_W'($urandom);
                bus.data_i[k] = DATA_W'($urandom);
            end
            settle();
`ifdef REG_ARB_PC_PRIORITY_EN
            spec_g = 4'b0001;
`else
            spec_g = NUM_REQ'(1 << (i % NUM_REQ));
`endif
            n_vec++;
            if (bus.gnt_o !== spec_g) begin
                n_err++; $display("FAIL rr_gnt cyc=%0d got %b want %b", i, bus.gnt_o, spec_g);
            end
            if (i > 0) begin
                n_vec++;
                if ({bus.wen_o, bus.wa_o, bus.write_data_o} !== {m_wen, m_wa, m_wd}) begin
                    n_err++; $display("FAIL rr_wr cyc=%0d got %b/%0d/%h want %b/%0d/%h", i,
                        bus.wen_o, bus.wa_o, bus.write_data_o, m_wen, m_wa, m_wd);
                end
            end
            tick();
        end
        drive_idle();
    endtask

    task automatic test_lock_timeout();
        int busy_cnt = 0;
        do_reset();
        bus.req_i = 4'b0010;
        settle(); tick();
        bus.req_i  = 4'b0110;
        bus.lock_i = 4'b0100;
        for (int i = 0; i < 6; i++) begin
            settle();
            n_vec++;
            if ({bus.gnt_o, bus.busy_o} !== {e_gnt, e_busy}) begin
                n_err++; $display("FAIL lock_to cyc=%0d got gnt=%b busy=%b want %b/%b", i, bus.gnt_o, bus.busy_o, e_gnt, e_busy);
            end
            if (i == 5) begin
                n_vec++;
                if (bus.gnt_o !== 4'b0010) begin
                    n_err++; $display("FAIL lock_to_resume got %b want 0010", bus.gnt_o);
                end
            end
            if (bus.busy_o === 1'b1) busy_cnt++;
            tick();
        end
        n_vec++;
        if (busy_cnt != LOCK_MAX) begin
            n_err++; $display("FAIL lock_to_busy got %0d busy cycles want %0d", busy_cnt, LOCK_MAX);
        end
        drive_idle();
    endtask

    task automatic test_lock_release();
        logic [NUM_REQ-1:0] spec_g;
        do_reset();
        bus.req_i = 4'b0001;
        settle(); tick();
        bus.req_i  = 4'b0010;
        bus.lock_i = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            bus.addr_i[1] = (i == 2) ? 3'd3 : ADDR_W'(i + 1);
            bus.data_i[1] = (i == 2) ? 8'hA5 : DATA_W'(i + 1);
            if (i == 2) bus.lock_i = '0;
            settle();
            n_vec++;
            if (bus.gnt_o !== 4'b0010 || bus.gnt_o !== e_gnt) begin
                n_err++; $display("FAIL lock_rel_gnt cyc=%0d got %b want 0010", i, bus.gnt_o);
            end
            tick();
        end
        bus.req_i = '0;
        settle();
        n_vec++;
        if ({bus.wen_o, bus.wa_o, bus.write_data_o, bus.busy_o} !== {1'b1, 3'd3, 8'hA5, 1'b0}) begin
            n_err++; $display("FAIL lock_rel_wr got wen=%b wa=%0d wd=%h busy=%b want 1/3/a5/0",
                bus.wen_o, bus.wa_o, bus.write_data_o, bus.busy_o);
        end
        bus.req_i = '1;
        settle();
`ifdef REG_ARB_PC_PRIORITY_EN
        spec_g = 4'b0001;
`else
        spec_g = 4'b0100;
`endif
        n_vec++;
        if (bus.gnt_o !== spec_g) begin
            n_err++; $display("FAIL lock_rel_rr got %b want %b", bus.gnt_o, spec_g);
        end
        tick();
        drive_idle();
    endtask

    task automatic test_same_addr();
        logic [DATA_W-1:0] rf2 = '0;
        logic [DATA_W-1:0] spec_d;
        logic [NUM_REQ-1:0] granted;
        do_reset();
        bus.req_i = 4'b0100;
        settle(); tick();
        bus.req_i     = 4'b1001;
        bus.addr_i[0] = 3'd2; bus.data_i[0] = 8'h11;
        bus.addr_i[3] = 3'd2; bus.data_i[3] = 8'h22;
        for (int i = 0; i < 4; i++) begin
            settle();
            n_vec++;
            if (bus.gnt_o !== e_gnt) begin
                n_err++; $display("FAIL same_addr_gnt cyc=%0d got %b want %b", i, bus.gnt_o, e_gnt);
            end
            granted = bus.gnt_o;
            tick();
            if (bus.wen_o === 1'b1 && bus.wa_o === 3'd2) rf2 = bus.write_data_o;
            bus.req_i = bus.req_i & ~granted;
        end
`ifdef REG_ARB_PC_PRIORITY_EN
        spec_d = 8'h22;
`else
        spec_d = 8'h11;
`endif
        n_vec++;
        if (rf2 !== spec_d) begin
            n_err++; $display("FAIL same_addr_rf got %h want %h", rf2, spec_d);
        end
        drive_idle();
    endtask

    task automatic test_random();
        logic [NUM_REQ-1:0] granted;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            reset = ($urandom_range(0, 99) == 0);
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!bus.req_i[k] && $urandom_range(0, 2) == 0) begin
                    bus.req_i[k]  = 1'b1;
                    bus.addr_i[k] = ADDR_W'($urandom);
                    bus.data_i[k] = DATA_W'($urandom);
                end
                bus.lock_i[k] = bus.req_i[k] ? ($urandom_range(0, 3) != 0) : 1'b0;
            end
            settle();
            n_vec++;
            if ({bus.gnt_o, bus.busy_o, bus.wen_o} !== {e_gnt, e_busy, m_wen}) begin
                n_err++; $display("FAIL rand_ctl cyc=%0d got gnt=%b busy=%b wen=%b want %b/%b/%b",
                    cyc, bus.gnt_o, bus.busy_o, bus.wen_o, e_gnt, e_busy, m_wen);
            end
            if (m_wen) begin
                n_vec++;
                if ({bus.wa_o, bus.write_data_o} !== {m_wa, m_wd}) begin
                    n_err++; $display("FAIL rand_wr cyc=%0d got %0d/%h want %0d/%h",
                        cyc, bus.wa_o, bus.write_data_o, m_wa, m_wd);
                end
            end
            granted = bus.gnt_o;
            tick();
            bus.req_i = bus.req_i & ~granted;
        end
        reset = 1'b0;
        drive_idle();
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_round_robin();
        test_lock_timeout();
        test_lock_release();
        test_same_addr();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
